// File: rtl/fsm_pattern_pkg.sv
// Shared definitions for the pattern transmitter: one-hot state encoding,
// default timing constants and the default phase counter width.
package fsm_pattern_pkg;

  localparam int STATE_W         = 6;
  localparam int HIGH_CYC_DEF    = 4;
  localparam int LOW_CYC_DEF     = 4;
  localparam int ACK_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF       = 8;

  // One-hot encoding. Any pattern not listed here is illegal and recovers to IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 6'b000001,
    ST_P1_HIGH  = 6'b000010,
    ST_GAP_LOW  = 6'b000100,
    ST_P2_HIGH  = 6'b001000,
    ST_WAIT_ACK = 6'b010000,
    ST_TAIL_LOW = 6'b100000
  } state_e;

endpackage

// File: rtl/fsm_pattern_tx_counter.sv
// pattern_phase_counter: loadable up/down phase counter.
// Ports:
//   clk, reset       clock, synchronous active-low reset (counter -> 0)
//   clear_i          force counter to 0 (highest priority)
//   load_i/load_val_i load a value (next priority)
//   dec_i / inc_i    decrement / increment (dec wins if both asserted)
//   zero_o           counter == 0
//   at_limit_o       counter == LIMIT
module pattern_phase_counter #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic             zero_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (dec_i)  cnt_d = cnt_q - 1'b1;
    else if (inc_i)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o     = (cnt_q == '0);
  assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/fsm_pattern_tx.sv
// fsm_pattern_tx: transmit side of the single-wire handshake pattern.
// Drives a_out high -> low -> high, waits for the receiver's acknowledge,
// then returns a_out low. All outputs are registered.
// Ports:
//   clk, reset   clock (rising edge), synchronous active-low reset
//   go           frame request, sampled only in IDLE (also in the done cycle)
//   ack_in       acknowledge from the receiver, only looked at in WAIT_ACK
//   a_out        pattern line to the receiver
//   busy         high while a frame is in progress
//   done         one-cycle pulse in the first IDLE cycle after a frame
//   err          sticky timeout flag, cleared by reset or by the next accepted go
//   state_dbg    current one-hot state, for observation only
//
// Handshake: go is a level request; it is accepted on any edge where the FSM is
// in IDLE and go==1, and ignored (not queued) otherwise. ack_in is a level
// acknowledge accepted on any edge in WAIT_ACK; it wins over a same-cycle timeout.
module fsm_pattern_tx
  import fsm_pattern_pkg::*;
#(
  parameter int HIGH_CYC    = HIGH_CYC_DEF,
  parameter int LOW_CYC     = LOW_CYC_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               ack_in,
  output logic               a_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYC - 1);

  state_e state_q, state_d;
  logic   a_q, a_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;

  logic             cnt_clear, cnt_load, cnt_dec, cnt_inc;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero, cnt_at_limit;

  pattern_phase_counter #(
    .CNT_W (CNT_W),
    .LIMIT (ACK_TIMEOUT - 1)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .inc_i      (cnt_inc),
    .zero_o     (cnt_zero),
    .at_limit_o (cnt_at_limit)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        a_d    = 1'b0;
        busy_d = 1'b0;
        if (go) begin
          state_d      = ST_P1_HIGH;
          a_d          = 1'b1;
          busy_d       = 1'b1;
          err_d        = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = HIGH_LOAD;
        end
      end
      ST_P1_HIGH: begin
        if (cnt_zero) begin
          state_d      = ST_GAP_LOW;
          a_d          = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = LOW_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GAP_LOW: begin
        if (cnt_zero) begin
          state_d      = ST_P2_HIGH;
          a_d          = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = HIGH_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_P2_HIGH: begin
        if (cnt_zero) begin
          // Counter switches to counting up the acknowledge wait.
          state_d   = ST_WAIT_ACK;
          a_d       = 1'b1;
          cnt_clear = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_in) begin
          state_d      = ST_TAIL_LOW;
          a_d          = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = LOW_LOAD;
        end else if (cnt_at_limit) begin
          state_d   = ST_IDLE;
          a_d       = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_clear = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_TAIL_LOW: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        a_d       = 1'b0;
        busy_d    = 1'b0;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign a_out     = a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
